// File: rtl/intt_stage_ctrl_pkg.sv
// Shared types, constants and butterfly address arithmetic for the INTT stage sequencer.
// Addresses follow a Gentleman-Sande schedule with twiddle tables for all stages packed back to back.
package intt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_A  = 2'd0,
    SEL_B  = 2'd1,
    SEL_TW = 2'd2
  } addr_sel_e;

  localparam int DEF_LOGN    = 12;
  localparam int RING_SIZE   = 1 << DEF_LOGN;
  localparam int CIPHER_SIZE = 2 * RING_SIZE;
  localparam int RD_LAT      = 1;

  // One of the (a, b, tw) addresses of butterfly j in stage s of a 2**logn point transform.
  function automatic int unsigned intt_addr(addr_sel_e sel, int unsigned logn,
                                            int unsigned s, int unsigned j);
    int unsigned h;
    int unsigned g;
    int unsigned k;
    int unsigned a;
    h = 32'd1 << s;
    g = j >> s;
    k = j & (h - 32'd1);
    a = (g << (s + 32'd1)) | k;
    case (sel)
      SEL_A:   return a;
      SEL_B:   return a + h;
      default: return ((32'd1 << logn) - ((32'd1 << logn) >> s)) + g;
    endcase
  endfunction

endpackage

// File: rtl/intt_stage_ctrl_addr_gen.sv
// Combinational butterfly address generator: maps (stage, butterfly index) to
// RAM operand addresses and the shared w/wp twiddle ROM address.
import intt_pkg::*;

module intt_addr_gen #(
  parameter int LOGN = 12,
  localparam int SW = $clog2(LOGN)
) (
  input  logic [SW-1:0]   i_stage,
  input  logic [LOGN-2:0] i_bfly,
  output logic [LOGN-1:0] o_addr_a,
  output logic [LOGN-1:0] o_addr_b,
  output logic [LOGN-1:0] o_tw_addr
);

  assign o_addr_a  = LOGN'(intt_addr(SEL_A,  LOGN, 32'(i_stage), 32'(i_bfly)));
  assign o_addr_b  = LOGN'(intt_addr(SEL_B,  LOGN, 32'(i_stage), 32'(i_bfly)));
  assign o_tw_addr = LOGN'(intt_addr(SEL_TW, LOGN, 32'(i_stage), 32'(i_bfly)));

endmodule

// File: rtl/intt_stage_ctrl.sv
// Stage sequencer for the INTT butterfly core: walks all LOGN stages, issues reads,
// and replays the read addresses L cycles later as in-place write-backs.
import intt_pkg::*;

module intt_stage_ctrl #(
  parameter int LOGN     = 12,
  parameter int CORE_LAT = 1,
  localparam int SW = $clog2(LOGN)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_rd_en,
  output logic [LOGN-1:0] o_rd_addr_a,
  output logic [LOGN-1:0] o_rd_addr_b,
  output logic [LOGN-1:0] o_tw_addr,
  output logic            o_wr_en,
  output logic [LOGN-1:0] o_wr_addr_a,
  output logic [LOGN-1:0] o_wr_addr_b,
  output logic [SW-1:0]   o_stage,
  output logic [1:0]      o_state
);

  localparam int L  = RD_LAT + CORE_LAT;
  localparam int DW = (L > 1) ? $clog2(L) : 1;
  localparam int JW = LOGN - 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(L - 1);

  state_e          r_state;
  logic [JW-1:0]   r_j;
  logic [SW-1:0]   r_s;
  logic [SW-1:0]   r_stage;
  logic [DW-1:0]   r_dcnt;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_en;
  logic [LOGN-1:0] r_rd_a;
  logic [LOGN-1:0] r_rd_b;
  logic [LOGN-1:0] r_tw;
  logic [LOGN-1:0] w_a;
  logic [LOGN-1:0] w_b;
  logic [LOGN-1:0] w_tw;

  logic [L-1:0]    r_dl_en;
  logic [LOGN-1:0] r_dl_a [L];
  logic [LOGN-1:0] r_dl_b [L];

  // r_s/r_j name the next butterfly to issue, so its addresses are ready to register.
  intt_addr_gen #(.LOGN(LOGN)) u_addr_gen (
    .i_stage   (r_s),
    .i_bfly    (r_j),
    .o_addr_a  (w_a),
    .o_addr_b  (w_b),
    .o_tw_addr (w_tw)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_j     <= '0;
      r_s     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_stage <= '0;
            r_rd_en <= 1'b1;
            r_rd_a  <= w_a;
            r_rd_b  <= w_b;
            r_tw    <= w_tw;
            r_j     <= r_j + JW'(1);
          end
        end
        ST_RUN: begin
          // r_j wraps to zero once the last butterfly of the stage is on the outputs.
          if (r_j == '0) begin
            r_state <= ST_DRAIN;
            r_dcnt  <= '0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            r_s     <= (r_s == LAST_STAGE) ? '0 : r_s + SW'(1);
          end else begin
            r_rd_a <= w_a;
            r_rd_b <= w_b;
            r_tw   <= w_tw;
            r_j    <= r_j + JW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_dcnt == DRAIN_LAST) begin
            if (r_stage == LAST_STAGE) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_stage <= '0;
            end else begin
              r_state <= ST_RUN;
              r_stage <= r_s;
              r_rd_en <= 1'b1;
              r_rd_a  <= w_a;
              r_rd_b  <= w_b;
              r_tw    <= w_tw;
              r_j     <= r_j + JW'(1);
            end
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dl_en <= '0;
      for (int i = 0; i < L; i++) begin
        r_dl_a[i] <= '0;
        r_dl_b[i] <= '0;
      end
    end else begin
      r_dl_en[0] <= r_rd_en;
      r_dl_a[0]  <= r_rd_a;
      r_dl_b[0]  <= r_rd_b;
      for (int i = 1; i < L; i++) begin
        r_dl_en[i] <= r_dl_en[i-1];
        r_dl_a[i]  <= r_dl_a[i-1];
        r_dl_b[i]  <= r_dl_b[i-1];
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr_a = r_rd_a;
  assign o_rd_addr_b = r_rd_b;
  assign o_tw_addr   = r_tw;
  assign o_wr_en     = r_dl_en[L-1];
  assign o_wr_addr_a = r_dl_a[L-1];
  assign o_wr_addr_b = r_dl_b[L-1];
  assign o_stage     = r_stage;
  assign o_state     = r_state;

endmodule

// File: tb/tb_intt_stage_ctrl.sv
// Bench for intt_stage_ctrl with N=8, CORE_LAT=1: expected reads, writes and done pulses are queued
// with their cycle numbers at start time; a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps
module tb_intt_stage_ctrl;

  localparam int LOGN      = 3;
  localparam int N         = 8;
  localparam int Q         = 17;
  localparam int W         = 32;
  localparam int STAGE_CYC = 6;
  localparam int DONE_CYC  = 19;
  localparam int MAXC      = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_a, rd_b, tw, wr_a, wr_b;
  logic [1:0] stage, state;

  always #5 clk = ~clk;

  intt_stage_ctrl #(.LOGN(LOGN), .CORE_LAT(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
    .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_tw_addr(tw),
    .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b),
    .o_stage(stage), .o_state(state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 1, 2, 3, 4, 4, 5, 5, 6, 6, 6, 6};

  logic [W-1:0] rd_q[$];
  logic [W-1:0] wr_q[$];
  logic [W-1:0] done_q[$];
  logic         exp_busy [MAXC];
  int           n_checks = 0;
  int           n_errors = 0;

  // Stub RAM + twiddle ROM + ideal butterfly core with one cycle of latency.
  int   ram [N];
  int   init_vec [N] = '{3, 1, 4, 1, 5, 9, 2, 6};
  int   tw_rom [N]   = '{2, 5, 7, 3, 11, 13, 6, 1};
  int   model [N];
  int   ram_qa, ram_qb, rom_q, core_a, core_b;
  logic load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) ram[i] <= init_vec[i];
    end else if (wr_en) begin
      ram[wr_a] <= core_a;
      ram[wr_b] <= core_b;
    end
    if (rd_en) begin
      ram_qa <= ram[rd_a];
      ram_qb <= ram[rd_b];
      rom_q  <= tw_rom[tw];
    end
    core_a <= (ram_qa + ram_qb) % Q;
    core_b <= ((ram_qa - ram_qb + Q) * rom_q) % Q;
  end

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string nm, logic [W-1:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", nm, act, cyc);
  endfunction

  function automatic logic [W-1:0] pk(int c, int s, int a, int b, int t);
    return {16'(c), 4'(s), 4'(a), 4'(b), 4'(t)};
  endfunction

  function automatic void push_run(int t0);
    for (int s = 0; s < LOGN; s++) begin
      for (int j = 0; j < N/2; j++) begin
        int c;
        int idx;
        c   = t0 + 1 + s*STAGE_CYC + j;
        idx = s*(N/2) + j;
        rd_q.push_back(pk(c, s, exp_a[idx], exp_b[idx], exp_tw[idx]));
        wr_q.push_back(pk(c + 2, 0, exp_a[idx], exp_b[idx], 0));
      end
    end
    done_q.push_back(pk(t0 + DONE_CYC, 0, 0, 0, 0));
    for (int c = t0 + 1; c < t0 + DONE_CYC; c++) exp_busy[c] = 1'b1;
  endfunction

  function automatic void run_model();
    for (int s = 0; s < LOGN; s++) begin
      int h;
      h = 1 << s;
      for (int blk = 0; blk < N; blk += 2*h) begin
        for (int k = 0; k < h; k++) begin
          int ia, ib, t, x, y;
          ia = blk + k;
          ib = ia + h;
          t  = N - (N >> s) + blk / (2*h);
          x  = model[ia];
          y  = model[ib];
          model[ia] = (x + y) % Q;
          model[ib] = ((x - y + Q) * tw_rom[t]) % Q;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_q.size() == 0) unexpected("rd_extra", pk(cyc, int'(stage), int'(rd_a), int'(rd_b), int'(tw)));
      else chk("rd_seq", pk(cyc, int'(stage), int'(rd_a), int'(rd_b), int'(tw)), rd_q.pop_front());
    end else begin
      chk("rd_idle_addr", 32'({rd_a, rd_b, tw}), 32'd0);
    end
    if (wr_en) begin
      if (wr_q.size() == 0) unexpected("wr_extra", pk(cyc, 0, int'(wr_a), int'(wr_b), 0));
      else chk("wr_seq", pk(cyc, 0, int'(wr_a), int'(wr_b), 0), wr_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) unexpected("done_extra", pk(cyc, 0, 0, 0, 0));
      else chk("done_cycle", pk(cyc, 0, 0, 0, 0), done_q.pop_front());
    end
    if (cyc < MAXC) chk("busy", 32'(busy), 32'(exp_busy[cyc]));
  end

  task automatic do_start(output int t0);
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    push_run(t0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("queues_drained", 32'(rd_q.size() + wr_q.size() + done_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [W-1:0] all_outputs();
    return 32'({busy, done, rd_en, wr_en, rd_a, rd_b, tw, wr_a, wr_b, stage, state});
  endfunction

  initial begin
    int t0;
    for (int c = 0; c < MAXC; c++) exp_busy[c] = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 32'd0);
    reset = 1'b0;

    // Full transform on stub RAM against an in-place GS reference.
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int i = 0; i < N; i++) model[i] = init_vec[i];
    run_model();
    do_start(t0);
    wait_drain(60);
    for (int i = 0; i < N; i++) chk($sformatf("ram_final[%0d]", i), 32'(ram[i]), 32'(model[i]));

    // Second start during the run must be ignored.
    do_start(t0);
    while (cyc < t0 + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(60);

    // Asynchronous reset in cycle 10, then a clean restart.
    do_start(t0);
    while (cyc < t0 + 10) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("reset_async", all_outputs(), 32'd0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    for (int c = cyc + 1; c < MAXC; c++) exp_busy[c] = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    do_start(t0);
    wait_drain(60);

    // start held high: second transform begins in cycle 21.
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    push_run(t0);
    push_run(t0 + DONE_CYC + 1);
    while (cyc < t0 + DONE_CYC + 2) @(negedge clk);
    start = 1'b0;
    wait_drain(100);
    chk("final_state_idle", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
